// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, FSM encoding and decoded-field bundle
// for the operand-fetch stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } of_state_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic        needs_rf;
    } dec_t;

    // $0 reads as zero; a same-cycle writeback to a live index wins over RF.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  idx,
        input logic [31:0] rf_data,
        input logic        wb_valid,
        input logic [4:0]  wb_reg,
        input logic [31:0] wb_data
    );
        if (idx == 5'd0)
            return '0;
        else if (wb_valid && wb_reg == idx)
            return wb_data;
        else
            return rf_data;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational MIPS field decoder: splits the instruction word and
// derives destination, extended immediate and whether RF reads are needed.
module instr_decoder
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [5:0] opcode;
    logic       is_r;
    logic       is_j;
    logic       is_jal;
    logic       no_wr;
    logic       zext;

    assign opcode = instr[31:26];
    assign is_r   = (opcode == OP_RTYPE);
    assign is_j   = (opcode == OP_J);
    assign is_jal = (opcode == OP_JAL);
    assign no_wr  = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                    (opcode == OP_SW);
    assign zext   = (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                    (opcode == OP_XORI);

    always_comb begin
        dec          = '0;
        dec.opcode   = opcode;
        dec.funct    = is_r ? instr[5:0] : 6'd0;
        dec.shamt    = instr[10:6];
        dec.rs       = instr[25:21];
        dec.rt       = instr[20:16];
        dec.needs_rf = !(is_j || is_jal);

        unique case (1'b1)
            is_r:           dec.dest = instr[15:11];
            is_jal:         dec.dest = REG_RA;
            (is_j || no_wr): dec.dest = 5'd0;
            default:        dec.dest = instr[20:16];
        endcase

        unique case (1'b1)
            (is_j || is_jal): dec.imm = {4'b0, instr[25:0], 2'b00};
            zext:             dec.imm = {16'b0, instr[15:0]};
            default:          dec.imm = {{16{instr[15]}}, instr[15:0]};
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: accepts an instruction, reads rs/rt from the
// RegisterFile with writeback forwarding, and hands operands to execute.
module operand_fetch
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        rf_en,
    output logic [4:0]  rf_read_reg1,
    output logic [4:0]  rf_read_reg2,
    input  logic [31:0] rf_read_data1,
    input  logic [31:0] rf_read_data2,
    input  logic        rf_done,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [5:0]  op_opcode,
    output logic [5:0]  op_funct,
    output logic [4:0]  op_shamt,
    output logic [31:0] op_rs_data,
    output logic [31:0] op_rt_data,
    output logic [31:0] op_imm,
    output logic [4:0]  op_dest,
    output logic        rf_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    of_state_t        state;
    logic [CNT_W-1:0] cnt;
    dec_t             dec;

    instr_decoder u_dec (
        .instr (instr),
        .dec   (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            instr_ready  <= 1'b1;
            rf_en        <= 1'b0;
            rf_read_reg1 <= '0;
            rf_read_reg2 <= '0;
            op_valid     <= 1'b0;
            op_opcode    <= '0;
            op_funct     <= '0;
            op_shamt     <= '0;
            op_rs_data   <= '0;
            op_rt_data   <= '0;
            op_imm       <= '0;
            op_dest      <= '0;
            rf_timeout   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_ready <= 1'b0;
                        op_opcode   <= dec.opcode;
                        op_funct    <= dec.funct;
                        op_shamt    <= dec.shamt;
                        op_imm      <= dec.imm;
                        op_dest     <= dec.dest;
                        if (dec.needs_rf) begin
                            rf_en        <= 1'b1;
                            rf_read_reg1 <= dec.rs;
                            rf_read_reg2 <= dec.rt;
                            state        <= S_REQ;
                        end else begin
                            op_rs_data <= '0;
                            op_rt_data <= '0;
                            op_valid   <= 1'b1;
                            state      <= S_OUT;
                        end
                    end
                end
                S_REQ: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rf_done) begin
                        rf_en      <= 1'b0;
                        op_rs_data <= fwd_sel(rf_read_reg1, rf_read_data1,
                                              wb_valid, wb_reg, wb_data);
                        op_rt_data <= fwd_sel(rf_read_reg2, rf_read_data2,
                                              wb_valid, wb_reg, wb_data);
                        op_valid   <= 1'b1;
                        state      <= S_OUT;
                    end else if (cnt == CNT_LAST) begin
                        rf_en      <= 1'b0;
                        rf_timeout <= 1'b1;
                        op_rs_data <= '0;
                        op_rt_data <= '0;
                        op_valid   <= 1'b1;
                        state      <= S_OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (op_ready) begin
                        op_valid    <= 1'b0;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, randomized transactions
// against a behavioural model, and timeout / async-reset sequences.
module tb_operand_fetch;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic        rf_en;
    logic [4:0]  rf_read_reg1;
    logic [4:0]  rf_read_reg2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        rf_done = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [5:0]  op_opcode;
    logic [5:0]  op_funct;
    logic [4:0]  op_shamt;
    logic [31:0] op_rs_data;
    logic [31:0] op_rt_data;
    logic [31:0] op_imm;
    logic [4:0]  op_dest;
    logic        rf_timeout;

    operand_fetch #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .rf_en         (rf_en),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .rf_done       (rf_done),
        .wb_valid      (wb_valid),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_opcode     (op_opcode),
        .op_funct      (op_funct),
        .op_shamt      (op_shamt),
        .op_rs_data    (op_rs_data),
        .op_rt_data    (op_rt_data),
        .op_imm        (op_imm),
        .op_dest       (op_dest),
        .rf_timeout    (rf_timeout)
    );

    always #5 clk = ~clk;

    logic [31:0] rf_mem [32];
    assign rf_read_data1 = rf_mem[rf_read_reg1];
    assign rf_read_data2 = rf_mem[rf_read_reg2];

    typedef struct {
        logic [31:0] instr;
        int          wait_cyc;
        bit          wb_v;
        logic [4:0]  wb_r;
        logic [31:0] wb_d;
        int          rdy;
        bit          req_done;
        logic [31:0] e_imm;
        logic [4:0]  e_dest;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        int          lat;
        bit          timeout;
    } exp_t;

    int n_pass = 0;
    int n_total = 0;
    bit exp_to = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] rd_op(input logic [4:0] idx, input vec_t v);
        if (idx == 0) return 32'd0;
        if (v.wb_v && v.wb_r != 0 && v.wb_r == idx) return v.wb_d;
        return rf_mem[idx];
    endfunction

    function automatic exp_t model(input vec_t v);
        exp_t e;
        logic [5:0] op;
        bit j;
        op = v.instr[31:26];
        j = (op == 6'h02) || (op == 6'h03);
        e.opcode = op;
        e.shamt  = v.instr[10:6];
        e.funct  = (op == 6'h00) ? v.instr[5:0] : 6'd0;
        if (op == 6'h00) e.dest = v.instr[15:11];
        else if (op == 6'h03) e.dest = 5'd31;
        else if (op inside {6'h02, 6'h04, 6'h05, 6'h2B}) e.dest = 5'd0;
        else e.dest = v.instr[20:16];
        if (j) e.imm = (v.instr & 32'h03FF_FFFF) * 4;
        else if (op inside {6'h0C, 6'h0D, 6'h0E}) e.imm = v.instr & 32'h0000_FFFF;
        else if (v.instr[15]) e.imm = v.instr | 32'hFFFF_0000;
        else e.imm = v.instr & 32'h0000_FFFF;
        e.timeout = !j && (v.wait_cyc < 0 || v.wait_cyc >= TO);
        e.lat = j ? 1 : (e.timeout ? 2 + TO : 3 + v.wait_cyc);
        e.rs = (j || e.timeout) ? 32'd0 : rd_op(v.instr[25:21], v);
        e.rt = (j || e.timeout) ? 32'd0 : rd_op(v.instr[20:16], v);
        return e;
    endfunction

    task automatic run_txn(input string nm, input vec_t v, input exp_t e);
        int lat;
        int bad_rf;
        int bad_hold;
        chk({nm, ".idle_ready"}, 32'(instr_ready), 32'd1);
        instr = v.instr;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = $urandom;
        lat = 1;
        bad_rf = 0;
        while (!op_valid && lat < 40) begin
            if (!rf_en || rf_read_reg1 != v.instr[25:21] ||
                rf_read_reg2 != v.instr[20:16]) bad_rf++;
            wb_valid = 1'b1;
            wb_reg = v.instr[25:21];
            wb_data = 32'hBAD0_BAD0;
            if (lat == 1 && v.req_done) rf_done = 1'b1;
            if (lat >= 2 && lat - 2 == v.wait_cyc) begin
                rf_done = 1'b1;
                wb_valid = v.wb_v;
                wb_reg = v.wb_r;
                wb_data = v.wb_d;
            end
            @(posedge clk); #1;
            rf_done = 1'b0;
            wb_valid = 1'b0;
            lat++;
        end
        if (e.timeout) exp_to = 1'b1;
        chk({nm, ".latency"}, 32'(lat), 32'(e.lat));
        chk({nm, ".rf_en_held"}, 32'(bad_rf), 32'd0);
        chk({nm, ".rf_en_off"}, 32'(rf_en), 32'd0);
        chk({nm, ".opcode"}, 32'(op_opcode), 32'(e.opcode));
        chk({nm, ".funct"}, 32'(op_funct), 32'(e.funct));
        chk({nm, ".shamt"}, 32'(op_shamt), 32'(e.shamt));
        chk({nm, ".dest"}, 32'(op_dest), 32'(e.dest));
        chk({nm, ".imm"}, op_imm, e.imm);
        chk({nm, ".rs_data"}, op_rs_data, e.rs);
        chk({nm, ".rt_data"}, op_rt_data, e.rt);
        chk({nm, ".timeout"}, 32'(rf_timeout), 32'(exp_to));
        bad_hold = 0;
        for (int i = 0; i < v.rdy; i++) begin
            @(posedge clk); #1;
            if (!op_valid || instr_ready || op_rs_data != e.rs ||
                op_rt_data != e.rt || op_imm != e.imm ||
                op_dest != e.dest) bad_hold++;
        end
        chk({nm, ".hold"}, 32'(bad_hold), 32'd0);
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        chk({nm, ".released"}, {30'd0, op_valid, instr_ready}, 32'b01);
    endtask

    vec_t tbl [16];
    logic [5:0] op_tbl [12];

    initial begin
        vec_t v;
        exp_t e;
        for (int i = 0; i < 32; i++) rf_mem[i] = i * 100;
        rf_mem[0] = 32'hDEAD_BEEF;
        op_tbl = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                   6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h0A};
        tbl[0]  = '{32'h0022_1820, 1, 0, 0, 0, 0, 0, 32'h0000_1820, 3, 100, 200, 4};
        tbl[1]  = '{32'h3405_FFFF, 0, 0, 0, 0, 0, 0, 32'h0000_FFFF, 5, 0, 500, 3};
        tbl[2]  = '{32'h2005_FFFF, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 5, 0, 500, 3};
        tbl[3]  = '{32'h0C00_0010, 0, 0, 0, 0, 0, 0, 32'h0000_0040, 31, 0, 0, 1};
        tbl[4]  = '{32'h0022_1820, 0, 1, 1, 50, 0, 0, 32'h0000_1820, 3, 50, 200, 3};
        tbl[5]  = '{32'h0002_1820, 0, 1, 0, 50, 0, 0, 32'h0000_1820, 3, 0, 200, 3};
        tbl[6]  = '{32'h0022_1820, 0, 0, 0, 0, 5, 0, 32'h0000_1820, 3, 100, 200, 3};
        tbl[7]  = '{32'h1022_FFFC, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 100, 200, 3};
        tbl[8]  = '{32'hAC22_0008, 0, 0, 0, 0, 0, 0, 32'h0000_0008, 0, 100, 200, 3};
        tbl[9]  = '{32'h0022_1820, 2, 0, 0, 0, 1, 1, 32'h0000_1820, 3, 100, 200, 5};
        tbl[10] = '{32'h0BFF_FFFF, 0, 0, 0, 0, 2, 0, 32'h0FFF_FFFC, 0, 0, 0, 1};
        tbl[11] = '{32'h0022_1820, 0, 1, 2, 77, 0, 0, 32'h0000_1820, 3, 100, 77, 3};
        tbl[12] = '{32'h3027_8000, 0, 0, 0, 0, 0, 0, 32'h0000_8000, 7, 100, 700, 3};
        tbl[13] = '{32'h3827_8001, 0, 0, 0, 0, 0, 0, 32'h0000_8001, 7, 100, 700, 3};
        tbl[14] = '{32'h0022_1820, 15, 0, 0, 0, 0, 0, 32'h0000_1820, 3, 100, 200, 18};
        tbl[15] = '{32'h8C22_FFF0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF0, 2, 100, 200, 3};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready_valid_en_to",
            {28'd0, instr_ready, op_valid, rf_en, rf_timeout}, 32'b1000);
        chk("reset.op_imm", op_imm, 32'd0);
        chk("reset.idx_dest", {17'd0, rf_read_reg1, rf_read_reg2, op_dest}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            e = model(tbl[i]);
            e.imm = tbl[i].e_imm;
            e.dest = tbl[i].e_dest;
            e.rs = tbl[i].e_rs;
            e.rt = tbl[i].e_rt;
            e.lat = tbl[i].e_lat;
            run_txn($sformatf("vec%0d", i), tbl[i], e);
        end

        v = tbl[0];
        v.wait_cyc = -1;
        e = model(v);
        run_txn("timeout", v, e);
        chk("timeout.zero_data", op_rs_data | op_rt_data, 32'd0);
        run_txn("sticky", tbl[4], model(tbl[4]));

        for (int n = 0; n < 60; n++) begin
            int r;
            v = tbl[0];
            v.instr = $urandom;
            v.instr[31:26] = op_tbl[$urandom_range(0, 11)];
            if ($urandom_range(0, 4) == 0) v.instr[25:21] = 5'd0;
            r = $urandom_range(0, 9);
            v.wait_cyc = (r < 7) ? $urandom_range(0, 3) :
                         (r == 7) ? 15 : (r == 8) ? 16 : -1;
            v.wb_v = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 3);
            v.wb_r = (r == 0) ? v.instr[25:21] : (r == 1) ? v.instr[20:16] :
                     (r == 2) ? 5'd0 : 5'($urandom);
            v.wb_d = $urandom;
            v.rdy = $urandom_range(0, 3);
            v.req_done = 1'($urandom_range(0, 1));
            run_txn($sformatf("rnd%0d", n), v, model(v));
        end

        instr = 32'h0022_1820;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_wait.pre", {30'd0, rf_en, rf_timeout}, 32'b11);
        #2 rst_n = 1'b0;
        #1;
        exp_to = 1'b0;
        chk("rst_wait.en_to",
            {28'd0, rf_en, rf_timeout, op_valid, instr_ready}, 32'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn("after_rst", tbl[0], model(tbl[0]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
